// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Contents:
//   - RV32I load/store funct3 encodings (F3_*)
//   - FSM state enum (state_t)
//   - base byte-enable patterns for byte/half/word stores (WSTRB_*)
//   - access_bad(): illegal funct3 or misaligned address check
//   - store_wdata()/store_strb(): bus formatting of store data and byte enables
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

  // Stores only know B/H/W; loads add the unsigned BU/HU forms.
  // funct3[1:0] carries the access size for every legal encoding.
  function automatic logic access_bad(input logic [2:0] funct3,
                                      input logic [1:0] off,
                                      input logic       we);
    logic legal;
    logic mis;
    if (we) begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = |off;
      default: mis = 1'b0;
    endcase
    return !legal || mis;
  endfunction

  // Data is replicated across the word so the byte enables alone pick the lane.
  function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                              input logic [31:0] data);
    case (funct3[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] funct3,
                                            input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return WSTRB_B << off;
      2'b01:   return WSTRB_H << off;
      default: return WSTRB_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: picks the addressed byte/half out of a read word and
// sign- or zero-extends it according to funct3.
// Ports:
//   word   - 32-bit word returned by memory
//   offset - byte offset addr[1:0] of the load
//   funct3 - load size/sign encoding
//   result - aligned, extended value for writeback (0 for non-load encodings)
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      F3_W:    result = word;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit.
// Accepts a load/store from EX/MEM, runs one bus transaction and stalls the
// pipeline until it completes; returns aligned/extended load data in DONE.
//
// Bus handshake: a request transfers on a cycle where req_valid & req_ready
// are both high; req_valid, once raised, stays high with all req_* stable until
// that transfer (or a timeout abort). A read response transfers on any cycle
// with rsp_valid high while waiting in RESP; there is no rsp_ready.
//
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   mem_read_in/..._in   - access request, funct3, byte address, store data
//   stall_out            - holds the upstream pipeline
//   load_data_out        - load result, valid in DONE, held otherwise
//   err_out              - one-cycle pulse: misaligned, illegal funct3, timeout
//   req_*                - request channel to data memory
//   rsp_valid/rsp_rdata  - read response channel
//   dbg_state            - current FSM state (dmem_pkg::state_t encoding)
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [31:0]           store_data_in,
  output logic                  stall_out,
  output logic [31:0]           load_data_out,
  output logic                  err_out,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [31:0]           req_wdata,
  output logic [3:0]            req_wstrb,
  input  logic                  rsp_valid,
  input  logic [31:0]           rsp_rdata,
  output logic [1:0]            dbg_state
);

  localparam int              CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TO_EN  = (TIMEOUT_CYCLES != 0);

  state_t state_q, state_d;

  // Request fields latched in IDLE, held for the whole transaction.
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;

  // Load result sources; updated only when a response is taken so the
  // output holds its value across later stores and in-flight accesses.
  logic [31:0] word_q;
  logic [1:0]  ld_off_q;
  logic [2:0]  ld_f3_q;

  logic [CNT_W-1:0] cnt_q;

  logic        acc;
  logic        we_in;
  logic        bad;
  logic        waiting;
  logic        timeout;
  logic        take;
  logic        bad_now;
  logic        rsp_take;
  logic [31:0] aligned;

  // Simultaneous read and write is treated as a load.
  assign acc     = mem_read_in | mem_write_in;
  assign we_in   = mem_write_in & ~mem_read_in;
  assign bad     = access_bad(funct3_in, addr_in[1:0], we_in);
  assign waiting = (state_q == S_REQ) || (state_q == S_RESP);
  assign timeout = TO_EN && waiting && (cnt_q == TO_MAX);

  always_comb begin
    state_d   = state_q;
    stall_out = 1'b0;
    err_out   = 1'b0;
    req_valid = 1'b0;
    take      = 1'b0;
    bad_now   = 1'b0;
    rsp_take  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (bad) begin
            err_out = 1'b1;
            bad_now = 1'b1;
          end else begin
            stall_out = 1'b1;
            take      = 1'b1;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_out = 1'b1;
        if (timeout) begin
          err_out = 1'b1;
          state_d = S_DONE;
        end else begin
          req_valid = 1'b1;
          if (req_ready) begin
            state_d = we_q ? S_DONE : S_RESP;
          end
        end
      end
      S_RESP: begin
        stall_out = 1'b1;
        if (timeout) begin
          err_out = 1'b1;
          state_d = S_DONE;
        end else if (rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
    end else if (take) begin
      off_q   <= addr_in[1:0];
      f3_q    <= funct3_in;
      we_q    <= we_in;
      addr_q  <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
      wdata_q <= we_in ? store_wdata(funct3_in, store_data_in) : 32'h0;
      wstrb_q <= we_in ? store_strb(funct3_in, addr_in[1:0]) : 4'b0000;
    end
  end

  // Counts REQ+RESP cycles from zero at REQ entry; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= '0;
    end else if (waiting && (cnt_q != TO_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= 32'h0;
      ld_off_q <= 2'b00;
      ld_f3_q  <= F3_W;
    end else if (bad_now || timeout) begin
      word_q   <= 32'h0;
      ld_off_q <= 2'b00;
      ld_f3_q  <= F3_W;
    end else if (rsp_take) begin
      word_q   <= rsp_rdata;
      ld_off_q <= off_q;
      ld_f3_q  <= f3_q;
    end
  end

  dmem_load_align u_align (
    .word   (word_q),
    .offset (ld_off_q),
    .funct3 (ld_f3_q),
    .result (aligned)
  );

  // A rejected access shows zero in its own cycle, before word_q clears.
  assign load_data_out = bad_now ? 32'h0 : aligned;
  assign req_we        = we_q;
  assign req_addr      = addr_q;
  assign req_wdata     = wdata_q;
  assign req_wstrb     = wstrb_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;
  import dmem_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        err_out;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {has_load_result, value} per accepted access, popped in DONE
  logic [32:0] exp_q[$];
  logic [31:0] last_ld = 32'h0;
  int          wait_cyc = 0;

  // expected request fields of the access in flight
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        cur_we;

  // snapshots taken by the driver for literal pins
  logic [31:0] snap_wdata, snap_addr, snap_ld;
  logic [3:0]  snap_wstrb;
  logic        snap_err, snap_stall, snap_rv;
  int          wait_n;

  dmem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .stall_out(stall_out), .load_data_out(load_data_out), .err_out(err_out),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic bit m_bad(input logic [2:0] f3, input int off, input logic we);
    bit legal;
    int sz;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz = f3 % 4;
    return !legal || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input int off, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h01010101;
      3'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input int off);
    case (f3)
      3'd0:    return 4'(1 << off);
      3'd1:    return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic        acc, we, bad, in_wait, to_now;
    logic [32:0] e;
    if (!rst_n) begin
      exp_q.delete();
      last_ld  = 32'h0;
      wait_cyc = 0;
    end else begin
      acc     = mem_read_in | mem_write_in;
      we      = mem_write_in & ~mem_read_in;
      bad     = m_bad(funct3_in, int'(addr_in[1:0]), we);
      in_wait = (dbg_state == S_REQ) || (dbg_state == S_RESP);
      to_now  = in_wait && (wait_cyc == TO);
      check("stall", stall_out, ((dbg_state == S_IDLE) && acc && !bad) || in_wait);
      check("err", err_out, ((dbg_state == S_IDLE) && acc && bad) || to_now);
      check("req_valid", req_valid, (dbg_state == S_REQ) && !to_now);
      if (req_valid) begin
        check("req_addr", req_addr, cur_addr);
        check("req_we", req_we, cur_we);
        if (cur_we) begin
          check("req_wdata", req_wdata, cur_wdata);
          check("req_wstrb", req_wstrb, cur_wstrb);
        end
      end
      if (dbg_state == S_DONE) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) last_ld = e[31:0];
          check("load_data_done", load_data_out, last_ld);
        end
      end else if ((dbg_state == S_IDLE) && acc && bad) begin
        last_ld = 32'h0;
        check("load_data_bad", load_data_out, last_ld);
      end else begin
        check("load_data_hold", load_data_out, last_ld);
      end
      wait_cyc = in_wait ? ((wait_cyc < TO) ? wait_cyc + 1 : wait_cyc) : 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input bit will_to, output bit was_bad);
    logic we;
    we = wr & ~rd;
    @(posedge clk); #1;
    mem_read_in = rd; mem_write_in = wr; funct3_in = f3;
    addr_in = addr; store_data_in = data;
    was_bad = m_bad(f3, int'(addr[1:0]), we);
    if (!was_bad) begin
      cur_addr  = addr & ~32'h3;
      cur_we    = we;
      cur_wdata = m_wdata(f3, data);
      cur_wstrb = m_wstrb(f3, int'(addr[1:0]));
      if (will_to)  exp_q.push_back({1'b1, 32'h0});
      else if (!we) exp_q.push_back({1'b1, m_load(rdata, int'(addr[1:0]), f3)});
      else          exp_q.push_back({1'b0, 32'h0});
    end
    #2;
    snap_err = err_out; snap_stall = stall_out; snap_rv = req_valid; snap_ld = load_data_out;
    @(posedge clk); #1;
    mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'b000;
    addr_in = 32'h0; store_data_in = 32'h0;
  endtask

  // rdy_dly/rsp_dly < 0 means never; returns at posedge+1 of the DONE cycle
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
    bit bad;
    bit will_to;
    int rq, rs, cyc;
    will_to = (rdy_dly < 0) || (!(wr & ~rd) && rsp_dly < 0);
    issue(rd, wr, f3, addr, data, rdata, will_to, bad);
    if (bad) return;
    rq = 0; rs = 0; cyc = 0; wait_n = 0;
    while (dbg_state != S_DONE && cyc < 40) begin
      req_ready = (dbg_state == S_REQ) && (rdy_dly >= 0) && (rq >= rdy_dly);
      if (dbg_state == S_RESP) begin
        rsp_valid = (rsp_dly >= 0) && (rs >= rsp_dly);
        rsp_rdata = rsp_valid ? rdata : $urandom;
      end else begin
        rsp_valid = (dbg_state == S_REQ);   // stray response, must be ignored
        rsp_rdata = $urandom;
      end
      #1;
      if (req_valid && req_ready) begin
        snap_wdata = req_wdata; snap_wstrb = req_wstrb; snap_addr = req_addr;
      end
      if (dbg_state == S_REQ) rq++;
      if (dbg_state == S_RESP) rs++;
      wait_n++;
      @(posedge clk); #1;
      cyc++;
    end
    req_ready = 1'b0; rsp_valid = 1'b0;
    if (dbg_state != S_DONE) check("done_reached", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit bad;
    rst_n = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'b000;
    addr_in = 32'h0; store_data_in = 32'h0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
    #1;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_stall", stall_out, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_load_data", load_data_out, 32'h0);
    check("rst_err", err_out, 1'b0);
    check("rst_wstrb", req_wstrb, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // stores
    do_op(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 3, 0);
    check("sw_addr", snap_addr, 32'h100);
    check("sw_wstrb", snap_wstrb, 4'b1111);
    check("sw_wdata", snap_wdata, 32'hDEADBEEF);
    check("sw_wait", wait_n, 4);
    do_op(1'b0, 1'b1, F3_B, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    check("sb_wdata", snap_wdata, 32'hA5A5A5A5);
    check("sb_wstrb", snap_wstrb, 4'b1000);
    do_op(1'b0, 1'b1, F3_H, 32'h102, 32'h00001234, 32'h0, 1, 0);
    check("sh_wdata", snap_wdata, 32'h12341234);
    check("sh_wstrb", snap_wstrb, 4'b1100);

    // loads
    do_op(1'b1, 1'b0, F3_B, 32'h201, 32'h0, 32'h000080FF, 0, 1);
    check("lb_data", load_data_out, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, F3_BU, 32'h201, 32'h0, 32'h000080FF, 0, 1);
    check("lbu_data", load_data_out, 32'h00000080);
    do_op(1'b1, 1'b0, F3_HU, 32'h202, 32'h0, 32'hBEEF0000, 1, 0);
    check("lhu_data", load_data_out, 32'h0000BEEF);
    do_op(1'b1, 1'b0, F3_H, 32'h202, 32'h0, 32'hBEEF0000, 0, 2);
    do_op(1'b1, 1'b0, F3_B, 32'h200, 32'h0, 32'h1234567F, 0, 0);
    do_op(1'b1, 1'b1, F3_W, 32'h204, 32'h55555555, 32'h89ABCDEF, 0, 0);
    check("rw_as_load", load_data_out, 32'h89ABCDEF);
    do_op(1'b0, 1'b1, F3_B, 32'h108, 32'h000000C3, 32'h0, 0, 0);

    // rejected accesses
    do_op(1'b1, 1'b0, F3_W, 32'h006, 32'h0, 32'h0, 0, 0);
    check("misal_err", snap_err, 1'b1);
    check("misal_stall", snap_stall, 1'b0);
    check("misal_req_valid", snap_rv, 1'b0);
    check("misal_load_data", snap_ld, 32'h0);
    do_op(1'b1, 1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0);
    check("f3_011_err", snap_err, 1'b1);
    check("f3_011_req_valid", snap_rv, 1'b0);
    do_op(1'b0, 1'b1, 3'b100, 32'h200, 32'h0, 32'h0, 0, 0);
    do_op(1'b0, 1'b1, F3_H, 32'h101, 32'h0, 32'h0, 0, 0);
    do_op(1'b1, 1'b0, 3'b110, 32'h200, 32'h0, 32'h0, 0, 0);

    // timeouts: load that never responds, store that is never accepted
    do_op(1'b1, 1'b0, F3_W, 32'h204, 32'h0, 32'h76543210, 0, 0);
    do_op(1'b1, 1'b0, F3_W, 32'h208, 32'h0, 32'h0, 0, -1);
    check("to_wait", wait_n, 5);
    check("to_load_data", load_data_out, 32'h0);
    @(posedge clk); #1;
    check("to_idle_next", dbg_state, S_IDLE);
    do_op(1'b0, 1'b1, F3_W, 32'h10C, 32'h11112222, 32'h0, -1, 0);
    check("to_st_wait", wait_n, 5);

    // reset while waiting in RESP
    do_op(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 32'hA0B0C0D0, 0, 0);
    issue(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'h0, 1'b0, bad);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    check("pre_rst_state", dbg_state, S_RESP);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_req_valid", req_valid, 1'b0);
    check("mid_rst_stall", stall_out, 1'b0);
    check("mid_rst_load_data", load_data_out, 32'h0);
    check("mid_rst_req_addr", req_addr, 32'h0);
    rsp_valid = 1'b1; rsp_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("late_rsp_state", dbg_state, S_IDLE);
    check("late_rsp_load_data", load_data_out, 32'h0);
    rsp_valid = 1'b0;
    do_op(1'b1, 1'b0, F3_W, 32'h304, 32'h0, 32'h13579BDF, 0, 1);
    check("post_rst_lw", load_data_out, 32'h13579BDF);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
MEM-stage data-memory access unit. It produces the load data and status that the MEM/WB pipeline register captures.
- Takes mem_read/mem_write/funct3, the ALU-computed address and the rs2 store data from EX/MEM.
- Drives a valid/ready request and response bus to data memory.
- Stalls the pipeline until the access completes.
- Returns byte/half/word loads aligned and extended, ready for the writeback mux.

Parameters:
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 255, max cycles waiting in REQ or RESP before abort; 0 disables timeout

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
mem_read_in  input  1  load request from EX/MEM
mem_write_in  input  1  store request from EX/MEM
funct3_in  input  3  access size/sign (RV32I load/store encoding)
addr_in  input  ADDR_WIDTH  byte address (alu_result)
store_data_in  input  32  rs2 value
stall_out  output  1  hold PC, IF/ID, ID/EX, EX/MEM
load_data_out  output  32  aligned, extended load result for MEM/WB mem_data
err_out  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout
req_valid  output  1  bus request valid
req_ready  input  1  bus accepts request
req_we  output  1  1 = store
req_addr  output  ADDR_WIDTH  word-aligned address (addr[1:0] = 0)
req_wdata  output  32  replicated store data
req_wstrb  output  4  byte enables
rsp_valid  input  1  read data valid
rsp_rdata  input  32  read word

Behaviour:

Reset:
- All outputs 0 and state IDLE.
- rst_n low at any time, including mid-transaction, returns to IDLE within the same cycle and drops req_valid.
- A response still pending on the bus is ignored after reset.

States: IDLE, REQ, RESP, DONE.
- acc = mem_read_in | mem_write_in. If both are set, treat as a load.
- bad = illegal funct3 (loads: 011/110/111; stores: anything other than 000/001/010) | misalignment (half: addr[0] != 0; word: addr[1:0] != 0).

IDLE:
- acc & bad: err_out = 1 for one cycle; no bus request; stall 0; load_data_out = 0; stay in IDLE.
- acc & !bad: latch addr[1:0], funct3, we, req_addr, wdata, wstrb; go to REQ.
- stall_out is combinational 1 in the IDLE cycle when acc & !bad.

REQ:
- req_valid = 1, with all req_* held stable until req_ready.
- On req_valid & req_ready: store goes to DONE; load goes to RESP.

RESP:
- Wait for rsp_valid.
- On rsp_valid, register rsp_rdata and go to DONE.
- rsp_valid in any other state is ignored. Minimum response latency is 1 cycle after acceptance.

DONE:
- stall_out = 0 and load_data_out is valid, so MEM/WB captures it on this edge.
- Next state is IDLE; the following instruction is seen in IDLE.

stall_out = (IDLE & acc & !bad) | REQ | RESP.

Timeout:
- Counter cleared on entry to REQ and counts REQ+RESP cycles.
- When the count reaches TIMEOUT_CYCLES: drop req_valid, err_out pulse, load_data 0, go to DONE.
- Counter saturates and never wraps.

Store formatting:
- SB: wdata = {4{byte}}, wstrb = 0001 << addr[1:0].
- SH: wdata = {2{half}}, wstrb = 0011 << addr[1:0].
- SW: wdata = word, wstrb = 1111.

Load extraction (combinational from the registered word and latched addr/funct3):
- LB/LBU: byte at addr[1:0], sign-/zero-extended.
- LH/LHU: half at addr[1], sign-/zero-extended.
- LW: full word.
- load_data_out holds its last value outside DONE. It is 0 after reset, after a bad access, and after a timeout.

Back-to-back accesses cost at least 3 cycles for a store and 4 for a load (IDLE, REQ, [RESP], DONE).

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - state enum
  - wstrb base constants
  - function returning bad for (funct3, addr[1:0], we)
- One natural combinational sub-module, dmem_load_align: word + offset + funct3 -> 32-bit result.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, req_ready held 0 for 3 cycles -> req_valid held with addr 0x100, wstrb 1111, stall high until DONE, err 0.
- SB addr 0x103 data 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 1000; SH addr 0x102 data 0x1234 -> wdata 0x12341234, wstrb 1100.
- LB addr 0x201, rsp_rdata 0x0000_80FF (rsp 2 cycles after accept) -> load_data 0xFFFFFF80 in DONE; LBU same -> 0x00000080; LHU addr 0x202, rdata 0xBEEF0000 -> 0x0000BEEF.
- LW addr 0x006 -> err pulse 1 cycle, no req_valid, stall 0, load_data 0; funct3 011 load -> same.
- TIMEOUT_CYCLES 4, load with rsp_valid never asserted -> err pulse, DONE with load_data 0, IDLE next cycle.
- rst_n asserted in RESP -> immediately IDLE, all outputs 0; a late rsp_valid is ignored; next LW completes normally.
